// File: rtl/program_counter_stack.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter_stack
//  Description : Program counter with increment, absolute jump, optional
//                relative branch, and a LIFO return-address stack for
//                call/return. Sticky overflow/underflow flags report stack
//                misuse until cleared by clrErr.
//                Optional feature macro: PC_REL_BRANCH_EN (enables brRel).
//  Revision    : 1.0 - initial release
// ============================================================================
module program_counter_stack #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rstPC,
  input  logic                               cePC,
  input  logic                               wrJumpAdr,
  input  logic [ADDR_W-1:0]                  jumpAdr,
  input  logic                               brRel,
  input  logic [ADDR_W-1:0]                  brOffset,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               clrErr,
  output logic [ADDR_W-1:0]                  out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stackCnt,
  output logic                               stackOvf,
  output logic                               stackUnf
);

  localparam int unsigned       c_cntW      = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] c_resetAddr = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] c_addrOne   = ADDR_W'(1);
  localparam logic [c_cntW-1:0] c_depth     = c_cntW'(STACK_DEPTH);
  localparam logic [c_cntW-1:0] c_cntOne    = c_cntW'(1);

  // The PC is held as an offset from RESET_ADDR (XOR-encoded), so an
  // all-zero power-up register state already reads back as RESET_ADDR.
  logic [ADDR_W-1:0] r_outOfs;
  logic [c_cntW-1:0] r_stackCnt;
  logic              r_stackOvf;
  logic              r_stackUnf;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0] w_out;
  logic [ADDR_W-1:0] w_outInc;
  logic [ADDR_W-1:0] w_outNext;
  logic [c_cntW-1:0] w_cntNext;
  logic [ADDR_W-1:0] w_top;
  logic              w_push;
  logic              w_ovfSet;
  logic              w_unfSet;
  logic              w_brTaken;
  logic [ADDR_W-1:0] w_brTarget;

  assign w_out    = r_outOfs ^ c_resetAddr;
  assign w_outInc = w_out + c_addrOne;

  // Relative branch is a build-time option; when absent the strobe never
  // wins arbitration and the request falls through to increment/hold.
`ifdef PC_REL_BRANCH_EN
  assign w_brTaken  = brRel;
  assign w_brTarget = w_out + brOffset;
`else
  logic w_unusedBr;
  assign w_brTaken  = 1'b0;
  assign w_brTarget = w_out;
  assign w_unusedBr = ^{brRel, brOffset};
`endif

  // Select the top-of-stack entry (index stackCnt-1); empty stack reads zero.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (r_stackCnt == c_cntW'(i + 1)) begin
        w_top = r_stack[i];
      end
    end
  end

  // Single prioritised action per cycle: rstPC > ret > call > jump > branch > inc.
  always_comb begin
    w_outNext = w_out;
    w_cntNext = r_stackCnt;
    w_push    = 1'b0;
    w_ovfSet  = 1'b0;
    w_unfSet  = 1'b0;
    if (rstPC) begin
      w_outNext = c_resetAddr;
      w_cntNext = '0;
    end else if (ret) begin
      if (r_stackCnt != '0) begin
        w_outNext = w_top;
        w_cntNext = r_stackCnt - c_cntOne;
      end else begin
        w_unfSet  = 1'b1;
      end
    end else if (call) begin
      if (r_stackCnt != c_depth) begin
        w_push    = 1'b1;
        w_outNext = jumpAdr;
        w_cntNext = r_stackCnt + c_cntOne;
      end else begin
        w_ovfSet  = 1'b1;
      end
    end else if (wrJumpAdr) begin
      w_outNext = jumpAdr;
    end else if (w_brTaken) begin
      w_outNext = w_brTarget;
    end else if (cePC) begin
      w_outNext = w_outInc;
    end
  end

  // PC, stack pointer and sticky flags; a new error outranks a clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_outOfs   <= '0;
      r_stackCnt <= '0;
      r_stackOvf <= 1'b0;
      r_stackUnf <= 1'b0;
    end else begin
      r_outOfs   <= w_outNext ^ c_resetAddr;
      r_stackCnt <= w_cntNext;
      r_stackOvf <= w_ovfSet | (r_stackOvf & ~clrErr);
      r_stackUnf <= w_unfSet | (r_stackUnf & ~clrErr);
    end
  end

  // Return-address storage: a push writes the slot just above the current top.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (rst && w_push && (r_stackCnt == c_cntW'(i))) begin
        r_stack[i] <= w_outInc;
      end
    end
  end

  assign out      = w_out;
  assign stackCnt = r_stackCnt;
  assign stackOvf = r_stackOvf;
  assign stackUnf = r_stackUnf;

endmodule
`default_nettype wire

// File: tb/tb_program_counter_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_counter_stack
//  Description : Scoreboard bench for program_counter_stack. A reference
//                model predicts each cycle's registered outputs and queues
//                them; a monitor pops and compares on the opposite edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter_stack;

  localparam int ADDR_W      = 8;
  localparam int STACK_DEPTH = 4;
  localparam int RESET_ADDR  = 0;
  localparam int CNT_W       = $clog2(STACK_DEPTH + 1);
  localparam int MASK        = (1 << ADDR_W) - 1;
`ifdef PC_REL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rstPC = 1'b0;
  logic              cePC = 1'b0;
  logic              wrJumpAdr = 1'b0;
  logic [ADDR_W-1:0] jumpAdr = '0;
  logic              brRel = 1'b0;
  logic [ADDR_W-1:0] brOffset = '0;
  logic              call = 1'b0;
  logic              ret = 1'b0;
  logic              clrErr = 1'b0;
  logic [ADDR_W-1:0] out;
  logic [CNT_W-1:0]  stackCnt;
  logic              stackOvf;
  logic              stackUnf;

  program_counter_stack #(
    .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .rstPC(rstPC), .cePC(cePC), .wrJumpAdr(wrJumpAdr),
    .jumpAdr(jumpAdr), .brRel(brRel), .brOffset(brOffset), .call(call),
    .ret(ret), .clrErr(clrErr), .out(out), .stackCnt(stackCnt),
    .stackOvf(stackOvf), .stackUnf(stackUnf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int out;
    int cnt;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: PC as an integer, stack as a queue (back = top).
  int mOut = RESET_ADDR;
  int mStack[$];
  bit mOvf = 1'b0;
  bit mUnf = 1'b0;

  function automatic void check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Model: evaluate the inputs present at the edge and queue the prediction.
  always @(posedge clk) begin
    bit ovfSet, unfSet;
    exp_t e;
    ovfSet = 1'b0;
    unfSet = 1'b0;
    if (!rst) begin
      mOut = RESET_ADDR;
      mStack.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else begin
      if (rstPC) begin
        mOut = RESET_ADDR;
        mStack.delete();
      end else if (ret) begin
        if (mStack.size() > 0) mOut = mStack.pop_back();
        else unfSet = 1'b1;
      end else if (call) begin
        if (mStack.size() < STACK_DEPTH) begin
          mStack.push_back((mOut + 1) & MASK);
          mOut = int'(jumpAdr);
        end else ovfSet = 1'b1;
      end else if (wrJumpAdr) begin
        mOut = int'(jumpAdr);
      end else if (BR_EN && brRel) begin
        mOut = (mOut + int'(brOffset)) & MASK;
      end else if (cePC) begin
        mOut = (mOut + 1) & MASK;
      end
      mOvf = ovfSet || (mOvf && !clrErr);
      mUnf = unfSet || (mUnf && !clrErr);
    end
    e.out = mOut;
    e.cnt = mStack.size();
    e.ovf = mOvf;
    e.unf = mUnf;
    sbq.push_back(e);
  end

  // Monitor: outputs are registered, so each prediction is due by the next falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      monE = sbq.pop_front();
      check("out",      int'(out),      monE.out);
      check("stackCnt", int'(stackCnt), monE.cnt);
      check("stackOvf", int'(stackOvf), int'(monE.ovf));
      check("stackUnf", int'(stackUnf), int'(monE.unf));
    end
  end

  task automatic drive(input bit iRst, input bit iRstPC, input bit iCe, input bit iWj,
                       input int iJa, input bit iBr, input int iOff,
                       input bit iCall, input bit iRet, input bit iClr);
    rst       = iRst;
    rstPC     = iRstPC;
    cePC      = iCe;
    wrJumpAdr = iWj;
    jumpAdr   = ADDR_W'(iJa);
    brRel     = iBr;
    brOffset  = ADDR_W'(iOff);
    call      = iCall;
    ret       = iRet;
    clrErr    = iClr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Power-up value before any clock edge.
    #1;
    check("powerup_out", int'(out), RESET_ADDR);

    // Reset, then three increments.
    drive(0, 0, 1, 1, 8'h33, 1, 1, 1, 1, 0);
    repeat (3) drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Increment wrap, relative branch backwards through zero.
    drive(1, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 8'h05, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 8'hFA, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 8'h7F, 0, 0, 0);

    // Call / return pair.
    drive(1, 0, 0, 1, 8'h10, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 8'h40, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Five nested calls (last overflows), then five returns (last underflows).
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 8'h80 + 8 * i, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // ret + call + cePC with one entry: pop wins.
    drive(1, 0, 0, 0, 8'h20, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 8'h60, 0, 0, 1, 1, 0);
    // rstPC with every strobe active.
    drive(1, 0, 0, 0, 8'h21, 0, 0, 1, 0, 0);
    drive(1, 1, 1, 1, 8'h99, 1, 3, 1, 1, 0);

    // Overflow, then clear racing a new overflow, then clear alone.
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 8'h30 + i, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 8'hEE, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of nested calls discards the stack.
    drive(1, 0, 0, 0, 8'h44, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 8'h44, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, MASK)),
            ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, MASK)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0));
    end

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_counter_stack.md
PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning program address width in bits (legal 4..16).
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, meaning return-address stack entries (legal 1..16).
REQ-003 The block SHALL have parameter RESET_ADDR, default 0, meaning the address loaded by any reset.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, global reset, synchronous and active-low.
REQ-006 The block SHALL have port rstPC, input, 1, decoder-driven synchronous PC clear, active-high.
REQ-007 The block SHALL have port cePC, input, 1, increment enable.
REQ-008 The block SHALL have port wrJumpAdr, input, 1, absolute jump strobe.
REQ-009 The block SHALL have port jumpAdr, input, ADDR_W, target address for jump and call.
REQ-010 The block SHALL have port brRel, input, 1, relative branch strobe.
REQ-011 The block SHALL have port brOffset, input, ADDR_W, two's-complement branch offset.
REQ-012 The block SHALL have port call, input, 1, subroutine call strobe.
REQ-013 The block SHALL have port ret, input, 1, subroutine return strobe.
REQ-014 The block SHALL have port clrErr, input, 1, clears sticky error flags.
REQ-015 The block SHALL have port out, output, ADDR_W, current program address, registered.
REQ-016 The block SHALL have port stackCnt, output, $clog2(STACK_DEPTH+1), occupied stack entries, registered.
REQ-017 The block SHALL have port stackOvf, output, 1, sticky overflow flag, registered.
REQ-018 The block SHALL have port stackUnf, output, 1, sticky underflow flag, registered.

Function
REQ-019 Per cycle exactly one action SHALL occur, priority: rstPC > ret > call > wrJumpAdr > brRel > cePC > hold.
REQ-020 rstPC SHALL load out=RESET_ADDR and empty the stack (stackCnt=0); flags unchanged.
REQ-021 ret with stackCnt>0 SHALL load out from top entry and decrement stackCnt.
REQ-022 ret with stackCnt=0 SHALL hold out, set stackUnf.
REQ-023 call with stackCnt<STACK_DEPTH SHALL push out+1 (mod 2^ADDR_W), load out=jumpAdr, increment stackCnt.
REQ-024 call with stackCnt=STACK_DEPTH SHALL hold out and stack contents, set stackOvf.
REQ-025 wrJumpAdr SHALL load out=jumpAdr.
REQ-026 brRel SHALL load out=out+brOffset, truncated to ADDR_W (wraps both directions).
REQ-027 cePC SHALL load out=out+1; all-ones wraps to 0.
REQ-028 All action results SHALL be visible on out one cycle after the strobe (latency 1).
REQ-029 clrErr SHALL clear both flags next cycle; a simultaneous new error SHALL win (flag stays 1).
REQ-030 Stack SHALL be LIFO; entries above stackCnt are don't-care and never observable.

Reset
REQ-031 rst=0 at a rising edge SHALL set out=RESET_ADDR, stackCnt=0, stackOvf=0, stackUnf=0, overriding all inputs.
REQ-032 rst asserted mid-sequence (e.g. during nested calls) SHALL discard all stack contents.
REQ-033 Power-up simulation value of out SHALL equal RESET_ADDR.

Configuration
REQ-034 Macro PC_REL_BRANCH_EN defined: brRel/brOffset behave per REQ-026.
REQ-035 Macro PC_REL_BRANCH_EN undefined: ports remain, brRel ignored, priority falls through to cePC/hold.

Verification
REQ-036 rst=0 one cycle, then cePC=1 for 3 cycles -> out 0,1,2,3; flags 0.
REQ-037 ADDR_W=8, out=0xFF, cePC=1 -> out=0x00; out=0x05, brRel=1, brOffset=0xFA -> out=0xFF.
REQ-038 out=0x10, call jumpAdr=0x40 -> out=0x40, stackCnt=1; ret -> out=0x11, stackCnt=0.
REQ-039 STACK_DEPTH=4: 5 calls -> after 5th out unchanged, stackCnt=4, stackOvf=1; 5 rets -> 4 valid returns then stackUnf=1.
REQ-040 Same cycle ret=1, call=1, cePC=1, stackCnt=1 -> pop only; rstPC=1 with all strobes -> out=RESET_ADDR, stackCnt=0.
REQ-041 stackOvf=1, clrErr=1 with overflowing call same cycle -> stackOvf stays 1; next cycle clrErr alone -> 0.
